mux4_rr_select: RTL and testbench
=================================

# mux4_rr_select

Round-robin select generator that sits directly upstream of the team's 2-bit, 4:1 conditional mux. It arbitrates among four requesting channels, drives the mux `select` lines, and runs a valid/ready handshake with the consumer of the mux output. It returns a one-hot acknowledge to the winning channel and keeps a wrapping transfer count. It never touches the 2-bit data path; data flows straight through the mux.

## Interface
Parameters:
- `CNT_W`, default 8: width of the transfer counter `xfer_cnt`.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req`, in, 4: `req[i]=1` means channel i holds valid data on mux input i. Held until acked, then updated no earlier than the cycle after ack.
- `mask`, in, 4: `mask[i]=0` excludes channel i from arbitration.
- `out_ready`, in, 1: consumer accepts the mux output this cycle.
- `select`, out, 2: drives the mux select; registered.
- `out_valid`, out, 1: mux output is valid; registered.
- `ack`, out, 4: one-hot, combinational. `ack[i] = out_valid & out_ready & (select==i) & ~rst`.
- `xfer_cnt`, out, CNT_W: count of completed transfers; registered, wraps.

## Operation
- Eligible vector `e = req & mask`, sampled each cycle.
- Internal pointer `last` (2 bits) holds the most recently granted channel.
- The block has two states.
- **IDLE**:
  - `out_valid=0`; `select` holds its value.
  - If `e != 0`, choose the first set bit of `e` searching `last+1, last+2, last+3, last` (mod 4).
  - Register the winner into `select` and `last`, set `out_valid=1`, and go to GRANT.
  - If `e == 0`, stay in IDLE.
- **GRANT**:
  - `out_valid=1` and `select` is stable until a transfer.
  - Transfer = `out_valid & out_ready`. On a transfer, `ack[select]=1` that cycle, `xfer_cnt` increments, and the next state is IDLE with `out_valid=0`.
  - Without a transfer, stay in GRANT indefinitely.
- The grant is never withdrawn. Deasserting `req[select]` or `mask[select]` while in GRANT has no effect until the transfer completes.
- Exactly one `ack` bit is high on a transfer cycle; all are zero otherwise.
- The single channel eligible repeatedly is re-granted every other cycle; its pointer wraps onto itself.
- `xfer_cnt` wraps from 2^CNT_W−1 to 0 with no flag.

## Timing
- Reset values: `select=2'b00`, `out_valid=0`, `ack=4'b0000`, `xfer_cnt=0`, `last=2'b11` (the first search starts at channel 0), state IDLE.
- Latency: `e` nonzero in cycle N gives `out_valid=1` with a valid `select` in cycle N+1.
- Throughput: at most one transfer per 2 cycles. Each transfer is followed by a mandatory IDLE cycle so requesters can update `req`.
- `ack` is valid in the transfer cycle itself. The requester samples it on the same edge on which the arbiter leaves GRANT.
- Reset mid-operation:
  - `rst=1` in GRANT with `out_ready=1` gives `ack=0` that cycle and no count increment.
  - All state returns to its reset values at that edge.
- `rst` has priority over every other input.
- `mask` and `req` changes in GRANT are ignored; they are re-evaluated only in IDLE.

## Test plan
- **Reset:** hold `rst=1` for 2 cycles with `req=4'b1111` and `out_ready=1` → `out_valid=0`, `ack=0`, `select=0`, `xfer_cnt=0`. Release → `select=0` and `out_valid=1` one cycle later.
- **Round-robin rotation:** `req=4'b1111`, `mask=4'b1111`, `out_ready=1`, requesters keep `req` high → grant sequence 0,1,2,3,0 with `out_valid` pattern 1,0,1,0,…; `ack`=0001,0010,0100,1000,0001; `xfer_cnt=5` after 10 cycles.
- **Backpressure:** grant channel 2 (`req=4'b0100`), hold `out_ready=0` for 5 cycles while toggling `req[2]` and `mask[2]` → `select=2` and `out_valid=1` stay stable and `ack=0`. Then `out_ready=1` → `ack=4'b0100` for one cycle, then `out_valid=0`.
- **Mask and skip:** `last=1`, `req=4'b1011`, `mask=4'b0111` → next grant is channel 0 (3 masked, 2 not requesting), `select=2'b00`.
- **Counter wrap:** `CNT_W=2`, run 5 transfers → `xfer_cnt` reads 1,2,3,0,1.
- **Reset during a transfer:** in GRANT with `select=3`, `out_ready=1`, `rst=1` → `ack=0`. The next cycle shows `out_valid=0`, `xfer_cnt` unchanged from reset (0), and `select=0`.

Source files
------------

// File: rtl/mux4_rr_select_if.sv
// Handshake/select bundle between the round-robin select generator and
// its requesters / mux consumer.
//   req       : per-channel request (channel i holds data on mux input i)
//   mask      : per-channel arbitration enable
//   out_ready : consumer accepts the mux output this cycle
//   select    : mux select lines (registered)
//   out_valid : mux output valid (registered)
//   ack       : one-hot acknowledge to the winning channel (combinational)
//   xfer_cnt  : wrapping count of completed transfers (registered)
interface mux4_rr_select_if #(
    parameter int unsigned CNT_W = 8
);
    logic [3:0]       req;
    logic [3:0]       mask;
    logic             out_ready;
    logic [1:0]       select;
    logic             out_valid;
    logic [3:0]       ack;
    logic [CNT_W-1:0] xfer_cnt;

    // Arbiter side.
    modport master (
        input  req,
        input  mask,
        input  out_ready,
        output select,
        output out_valid,
        output ack,
        output xfer_cnt
    );

    // Requester / consumer side.
    modport slave (
        output req,
        output mask,
        output out_ready,
        input  select,
        input  out_valid,
        input  ack,
        input  xfer_cnt
    );
endinterface

// File: rtl/mux4_rr_select.sv
// Round-robin select generator for a 4:1 mux with a valid/ready output
// handshake. Arbitrates among req & mask, holds the grant until the
// consumer accepts, acks the winner and counts completed transfers.
//   clk : rising-edge clock
//   rst : synchronous active-high reset (priority over all inputs)
//   bus : mux4_rr_select_if.master (req/mask/out_ready in;
//         select/out_valid/ack/xfer_cnt out)
module mux4_rr_select #(
    parameter int unsigned CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    mux4_rr_select_if.master    bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0]       elig_c;
    logic [1:0]       cand_c;
    logic [1:0]       win_c;
    logic             found_c;
    logic             xfer_c;

    assign elig_c = bus.req & bus.mask;
    assign xfer_c = valid_q & bus.out_ready;

    // Search last+1, last+2, last+3, last (mod 4); first eligible wins.
    always_comb begin
        cand_c  = last_q;
        win_c   = last_q;
        found_c = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand_c = last_q + 2'(k);
            if (!found_c && elig_c[cand_c]) begin
                win_c   = cand_c;
                found_c = 1'b1;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (found_c) begin
                    sel_d   = win_c;
                    last_d  = win_c;
                    valid_d = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Grant is held regardless of req/mask until the transfer.
                if (xfer_c) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State register; reset returns the pointer to 3 so channel 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 2'b00;
            last_q  <= 2'b11;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Ack is suppressed in a reset cycle so no transfer is reported.
    assign bus.ack       = (xfer_c && !rst) ? (4'b0001 << sel_q) : 4'b0000;
    assign bus.select    = sel_q;
    assign bus.out_valid = valid_q;
    assign bus.xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_mux4_rr_select.sv
// Directed self-checking bench for mux4_rr_select: reset, rotation,
// backpressure, mask/skip, counter wrap (CNT_W=2 instance) and reset
// during a transfer.
module tb_mux4_rr_select;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mux4_rr_select_if #(.CNT_W(8)) bus ();
    mux4_rr_select_if #(.CNT_W(2)) bus2 ();

    mux4_rr_select #(.CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mux4_rr_select #(.CNT_W(2)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 4'hF; bus.mask = 4'hF; bus.out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d]: got %0b expected 0", c, bus.out_valid); end
            checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL reset_ack[%0d]: got %b expected 0000", c, bus.ack); end
            checks++; if (bus.select !== 2'd0) begin errors++; $display("FAIL reset_select[%0d]: got %0d expected 0", c, bus.select); end
            checks++; if (bus.xfer_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt[%0d]: got %0d expected 0", c, bus.xfer_cnt); end
        end
        rst = 1'b0;
        #1;
        checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL reset_rel_ack: got %b expected 0000", bus.ack); end
        tick();
        checks++; if (bus.select !== 2'd0) begin errors++; $display("FAIL reset_first_sel: got %0d expected 0", bus.select); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL reset_first_valid: got %0b expected 1", bus.out_valid); end
        checks++; if (bus.ack !== 4'b0001) begin errors++; $display("FAIL reset_first_ack: got %b expected 0001", bus.ack); end
    endtask

    task automatic test_rotation();
        logic [1:0] exp_sel;
        logic [3:0] exp_ack;
        bus.req = 4'hF; bus.mask = 4'hF; bus.out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            exp_sel = 2'(i);
            exp_ack = 4'b0001 << exp_sel;
            tick();
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rot_valid[%0d]: got %0b expected 1", i, bus.out_valid); end
            checks++; if (bus.select !== exp_sel) begin errors++; $display("FAIL rot_sel[%0d]: got %0d expected %0d", i, bus.select, exp_sel); end
            checks++; if (bus.ack !== exp_ack) begin errors++; $display("FAIL rot_ack[%0d]: got %b expected %b", i, bus.ack, exp_ack); end
            tick();
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rot_idle[%0d]: got %0b expected 0", i, bus.out_valid); end
            checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL rot_idle_ack[%0d]: got %b expected 0000", i, bus.ack); end
            checks++; if (bus.xfer_cnt !== 8'(i + 1)) begin errors++; $display("FAIL rot_cnt[%0d]: got %0d expected %0d", i, bus.xfer_cnt, i + 1); end
        end
    endtask

    task automatic test_backpressure();
        bus.req = 4'b0100; bus.mask = 4'hF; bus.out_ready = 1'b0;
        do_reset();
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.req  = (i % 2 == 0) ? 4'b0000 : 4'b0100;
            bus.mask = (i % 2 == 0) ? 4'b1011 : 4'b1111;
            #1;
            checks++; if (bus.select !== 2'd2) begin errors++; $display("FAIL bp_sel[%0d]: got %0d expected 2", i, bus.select); end
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %0b expected 1", i, bus.out_valid); end
            checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL bp_ack[%0d]: got %b expected 0000", i, bus.ack); end
            tick();
        end
        bus.req = 4'b0100; bus.mask = 4'hF; bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.ack !== 4'b0100) begin errors++; $display("FAIL bp_release_ack: got %b expected 0100", bus.ack); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_after_valid: got %0b expected 0", bus.out_valid); end
        checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL bp_after_ack: got %b expected 0000", bus.ack); end
        checks++; if (bus.xfer_cnt !== 8'd1) begin errors++; $display("FAIL bp_cnt: got %0d expected 1", bus.xfer_cnt); end
    endtask

    task automatic test_mask_skip();
        bus.req = 4'b0010; bus.mask = 4'hF; bus.out_ready = 1'b1;
        do_reset();
        tick();
        checks++; if (bus.select !== 2'd1) begin errors++; $display("FAIL ms_first_sel: got %0d expected 1", bus.select); end
        checks++; if (bus.ack !== 4'b0010) begin errors++; $display("FAIL ms_first_ack: got %b expected 0010", bus.ack); end
        bus.req = 4'b1011; bus.mask = 4'b0111;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ms_idle_valid: got %0b expected 0", bus.out_valid); end
        tick();
        checks++; if (bus.select !== 2'd0) begin errors++; $display("FAIL ms_skip_sel: got %0d expected 0", bus.select); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ms_skip_valid: got %0b expected 1", bus.out_valid); end
        checks++; if (bus.ack !== 4'b0001) begin errors++; $display("FAIL ms_skip_ack: got %b expected 0001", bus.ack); end
        bus.req = 4'b0000; bus.mask = 4'hF;
        tick();
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ms_empty_valid: got %0b expected 0", bus.out_valid); end
        checks++; if (bus.xfer_cnt !== 8'd2) begin errors++; $display("FAIL ms_cnt: got %0d expected 2", bus.xfer_cnt); end
    endtask

    task automatic test_counter_wrap();
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        bus.req = 4'b0000;
        bus2.req = 4'b0001; bus2.mask = 4'hF; bus2.out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus2.out_valid !== 1'b1 || bus2.select !== 2'd0) begin errors++; $display("FAIL wrap_grant[%0d]: got valid %0b sel %0d expected valid 1 sel 0", i, bus2.out_valid, bus2.select); end
            tick();
            checks++; if (bus2.xfer_cnt !== exp_cnt[i]) begin errors++; $display("FAIL wrap_cnt[%0d]: got %0d expected %0d", i, bus2.xfer_cnt, exp_cnt[i]); end
        end
        bus2.req = 4'b0000;
    endtask

    task automatic test_reset_in_transfer();
        bus.req = 4'b1000; bus.mask = 4'hF; bus.out_ready = 1'b0;
        do_reset();
        tick();
        checks++; if (bus.select !== 2'd3 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL rt_grant: got sel %0d valid %0b expected sel 3 valid 1", bus.select, bus.out_valid); end
        bus.out_ready = 1'b1;
        rst = 1'b1;
        #1;
        checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL rt_ack: got %b expected 0000", bus.ack); end
        tick();
        rst = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rt_valid: got %0b expected 0", bus.out_valid); end
        checks++; if (bus.xfer_cnt !== 8'd0) begin errors++; $display("FAIL rt_cnt: got %0d expected 0", bus.xfer_cnt); end
        checks++; if (bus.select !== 2'd0) begin errors++; $display("FAIL rt_sel: got %0d expected 0", bus.select); end
    endtask

    initial begin
        rst = 1'b1;
        bus.req = 4'h0; bus.mask = 4'hF; bus.out_ready = 1'b0;
        bus2.req = 4'h0; bus2.mask = 4'hF; bus2.out_ready = 1'b0;
        test_reset();
        test_rotation();
        test_backpressure();
        test_mask_skip();
        test_counter_wrap();
        test_reset_in_transfer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
